// File: rtl/instr_fetch_pkg.sv
// Shared types for the Maluch fetch stage: instruction word layout, fetch FSM states.
// Optional HALT handling in instr_fetch is enabled by defining MALUCH_FETCH_HALT_EN.
package types;

  localparam int unsigned OPCODE_HI     = 15;
  localparam int unsigned OPCODE_LO     = 12;
  localparam int unsigned IMM_VALID_BIT = 11;
  localparam int unsigned FUNCT_HI      = 10;
  localparam int unsigned FUNCT_LO      = 8;
  localparam int unsigned DEST_HI       = 7;
  localparam int unsigned DEST_LO       = 4;
  localparam int unsigned SRC_HI        = 3;
  localparam int unsigned SRC_LO        = 0;

  localparam logic [3:0] HALT_OPCODE = 4'hF;
  localparam logic [2:0] HALT_FUNCT  = 3'b111;

  typedef struct packed {
    logic [3:0]  opcode;
    logic        imm_valid;
    logic [2:0]  funct;
    logic [3:0]  dest_reg;
    logic [3:0]  src_reg;
    logic [15:0] imm;
  } instr_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    OPW  = 3'd2,
    IMMW = 3'd3,
    OUT  = 3'd4,
    HALT = 3'd5
  } fetch_state_t;

  function automatic instr_t decode_first(input logic [15:0] w);
    instr_t i;
    i.opcode    = w[OPCODE_HI:OPCODE_LO];
    i.imm_valid = w[IMM_VALID_BIT];
    i.funct     = w[FUNCT_HI:FUNCT_LO];
    i.dest_reg  = w[DEST_HI:DEST_LO];
    i.src_reg   = w[SRC_HI:SRC_LO];
    i.imm       = 16'h0000;
    return i;
  endfunction

  function automatic logic is_halt(input instr_t i);
    return (i.opcode == HALT_OPCODE) && (i.funct == HALT_FUNCT);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of instruction-memory, consumer handshake and redirect signals of the fetch stage.
interface instr_fetch_if;
  import types::*;

  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  instr_t      instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halted;

  modport master (
    output mem_req, mem_addr, instr, instr_pc, instr_valid, halted,
    input  mem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_pc, instr_valid, halted,
    output mem_rdata, instr_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/instr_fetch.sv
// Maluch fetch stage: assembles one- or two-word instructions from synchronous memory.
// Define MALUCH_FETCH_HALT_EN to stop fetching after a HALT (opcode F, funct 7) is consumed.
module instr_fetch
  import types::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  instr_t       instr_q, instr_d;
  logic [15:0]  instr_pc_q, instr_pc_d;
  logic         mem_req_s;
  logic [15:0]  mem_addr_s;

  // Memory request depends only on state (and the opcode word for the imm prefetch).
  always_comb begin
    mem_req_s  = 1'b0;
    mem_addr_s = 16'h0000;
    case (state_q)
      REQ: begin
        mem_req_s  = 1'b1;
        mem_addr_s = pc_q;
      end
      OPW: begin
        if (bus.mem_rdata[IMM_VALID_BIT]) begin
          mem_req_s  = 1'b1;
          mem_addr_s = pc_q + 16'd1;
        end else begin
          mem_req_s  = 1'b0;
        end
      end
      default: mem_req_s = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    if (bus.redirect_valid) begin
      // In-flight read data is dropped by leaving instr untouched.
      pc_d    = bus.redirect_pc;
      state_d = REQ;
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ:  state_d = OPW;
        OPW: begin
          instr_d    = decode_first(bus.mem_rdata);
          instr_pc_d = pc_q;
          pc_d       = pc_q + 16'd1;
          if (bus.mem_rdata[IMM_VALID_BIT]) begin
            state_d = IMMW;
          end else begin
            state_d = OUT;
          end
        end
        IMMW: begin
          instr_d.imm = bus.mem_rdata;
          pc_d        = pc_q + 16'd1;
          state_d     = OUT;
        end
        OUT: begin
          if (bus.instr_ready) begin
`ifdef MALUCH_FETCH_HALT_EN
            state_d = is_halt(instr_q) ? HALT : REQ;
`else
            state_d = REQ;
`endif
          end else begin
            state_d = OUT;
          end
        end
`ifdef MALUCH_FETCH_HALT_EN
        HALT:    state_d = HALT;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign bus.mem_req     = mem_req_s;
  assign bus.mem_addr    = mem_addr_s;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = (state_q == OUT);
`ifdef MALUCH_FETCH_HALT_EN
  assign bus.halted      = (state_q == HALT);
`else
  assign bus.halted      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a synchronous 64K-word instruction memory model.
module tb_instr_fetch;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  instr_fetch_if bus_if();

  instr_fetch #(.RESET_PC(16'h0010)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  logic [15:0] mem [0:65535];

  always @(posedge clk) begin
    if (bus_if.mem_req) bus_if.mem_rdata <= mem[bus_if.mem_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h2812;
    mem[16'h0001] = 16'hBEEF;
    mem[16'h0010] = 16'h1234;
    mem[16'h0011] = 16'h3456;
    mem[16'h0012] = 16'h7A00;
    mem[16'h0013] = 16'h1111;
    mem[16'h0040] = 16'h9123;
    mem[16'h0080] = 16'hF700;
    mem[16'hFFFF] = 16'hC800;

    rst = 1'b1;
    bus_if.instr_ready    = 1'b1;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 16'h0000;
    step();
    step();
    chk("rst_mem_req", {31'd0, bus_if.mem_req}, 32'd0);
    chk("rst_mem_addr", {16'd0, bus_if.mem_addr}, 32'd0);
    chk("rst_instr", bus_if.instr, 32'h0000_0000);
    chk("rst_instr_pc", {16'd0, bus_if.instr_pc}, 32'd0);
    chk("rst_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, bus_if.halted}, 32'd0);

    rst = 1'b0;
    chk("idle_no_req", {31'd0, bus_if.mem_req}, 32'd0);
    step();
    chk("first_req", {31'd0, bus_if.mem_req}, 32'd1);
    chk("first_addr", {16'd0, bus_if.mem_addr}, 32'h0010);
    step();
    chk("opw_short_no_req", {31'd0, bus_if.mem_req}, 32'd0);
    chk("opw_not_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    step();
    chk("short_valid", {31'd0, bus_if.instr_valid}, 32'd1);
    chk("short_instr", bus_if.instr, 32'h1234_0000);
    chk("short_pc", {16'd0, bus_if.instr_pc}, 32'h0010);
    step();
    chk("b2b_req_addr", {15'd0, bus_if.mem_req, bus_if.mem_addr}, 32'h0001_0011);

    // consumer stalls for five cycles
    bus_if.instr_ready = 1'b0;
    step();
    step();
    chk("stall_instr", bus_if.instr, 32'h3456_0000);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold_instr", bus_if.instr, 32'h3456_0000);
      chk("stall_hold_pc", {16'd0, bus_if.instr_pc}, 32'h0011);
      chk("stall_no_req", {31'd0, bus_if.mem_req}, 32'd0);
      chk("stall_valid", {31'd0, bus_if.instr_valid}, 32'd1);
    end
    bus_if.instr_ready = 1'b1;
    step();
    chk("release_req", {15'd0, bus_if.mem_req, bus_if.mem_addr}, 32'h0001_0012);

    // redirect while the imm word is in flight
    step();
    chk("imm_req", {15'd0, bus_if.mem_req, bus_if.mem_addr}, 32'h0001_0013);
    step();
    chk("immw_not_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 16'h0040;
    step();
    bus_if.redirect_valid = 1'b0;
    chk("redir_req", {15'd0, bus_if.mem_req, bus_if.mem_addr}, 32'h0001_0040);
    chk("redir_not_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    step();
    chk("redir_opw_not_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    step();
    chk("redir_instr", bus_if.instr, 32'h9123_0000);
    chk("redir_pc", {16'd0, bus_if.instr_pc}, 32'h0040);

    // redirect in OUT together with a handshake
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 16'h0000;
    step();
    bus_if.redirect_valid = 1'b0;
    chk("redir0_req", {15'd0, bus_if.mem_req, bus_if.mem_addr}, 32'h0001_0000);
    chk("redir0_not_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    step();
    chk("long_imm_req", {15'd0, bus_if.mem_req, bus_if.mem_addr}, 32'h0001_0001);
    step();
    step();
    chk("long_instr", bus_if.instr, 32'h2812_BEEF);
    chk("long_pc", {16'd0, bus_if.instr_pc}, 32'h0000);
    step();
    chk("long_next_req", {15'd0, bus_if.mem_req, bus_if.mem_addr}, 32'h0001_0002);

    // long instruction at the top of memory wraps for its imm
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 16'hFFFF;
    step();
    bus_if.redirect_valid = 1'b0;
    chk("wrap_req", {15'd0, bus_if.mem_req, bus_if.mem_addr}, 32'h0001_FFFF);
    step();
    chk("wrap_imm_req", {15'd0, bus_if.mem_req, bus_if.mem_addr}, 32'h0001_0000);
    step();
    step();
    chk("wrap_instr", bus_if.instr, 32'hC800_2812);
    chk("wrap_pc", {16'd0, bus_if.instr_pc}, 32'h0000_FFFF);
    step();
    chk("wrap_next_req", {15'd0, bus_if.mem_req, bus_if.mem_addr}, 32'h0001_0001);

    // opcode F / funct 7
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 16'h0080;
    step();
    bus_if.redirect_valid = 1'b0;
    chk("f7_req", {15'd0, bus_if.mem_req, bus_if.mem_addr}, 32'h0001_0080);
    step();
    step();
    chk("f7_valid", {31'd0, bus_if.instr_valid}, 32'd1);
    chk("f7_instr", bus_if.instr, 32'hF700_0000);
    step();
`ifdef MALUCH_FETCH_HALT_EN
    chk("halt_flag", {31'd0, bus_if.halted}, 32'd1);
    chk("halt_not_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("halt_no_req", {31'd0, bus_if.mem_req}, 32'd0);
      chk("halt_stays", {31'd0, bus_if.halted}, 32'd1);
      step();
    end
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 16'h0000;
    step();
    bus_if.redirect_valid = 1'b0;
    chk("resume_halted", {31'd0, bus_if.halted}, 32'd0);
    chk("resume_req", {15'd0, bus_if.mem_req, bus_if.mem_addr}, 32'h0001_0000);
`else
    chk("nohalt_flag", {31'd0, bus_if.halted}, 32'd0);
    chk("nohalt_req", {15'd0, bus_if.mem_req, bus_if.mem_addr}, 32'h0001_0081);
`endif

    // asynchronous reset in the middle of an instruction
    step();
    rst = 1'b1;
    #1;
    chk("midrst_req", {31'd0, bus_if.mem_req}, 32'd0);
    chk("midrst_addr", {16'd0, bus_if.mem_addr}, 32'd0);
    chk("midrst_instr", bus_if.instr, 32'h0000_0000);
    chk("midrst_pc", {16'd0, bus_if.instr_pc}, 32'd0);
    chk("midrst_valid", {31'd0, bus_if.instr_valid}, 32'd0);
    chk("midrst_halted", {31'd0, bus_if.halted}, 32'd0);
    step();
    rst = 1'b0;
    chk("midrst_idle", {31'd0, bus_if.mem_req}, 32'd0);
    step();
    chk("midrst_refetch", {15'd0, bus_if.mem_req, bus_if.mem_addr}, 32'h0001_0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the Maluch core. Reads 16-bit words from a synchronous instruction memory, assembles one- or two-word instructions into a `types::instr_t`, and presents them to the decode/execute stage over a valid/ready handshake. Sits directly upstream of the stage that consumes `instr_t`. Accepts a PC redirect from execute.

## Interface
- `RESET_PC`, default 16'h0000: word address fetched first after reset.
- `clk  in  1`: clock, all state on rising edge.
- `rst  in  1`: reset, asynchronous, active-high.
- `mem_req  out  1`: read request this cycle.
- `mem_addr  out  16`: word address of the request.
- `mem_rdata  in  16`: read data, valid exactly one cycle after `mem_req`.
- `instr  out  $bits(instr_t)`: assembled instruction, `types::instr_t`.
- `instr_pc  out  16`: address of the instruction's first word.
- `instr_valid  out  1`: `instr`/`instr_pc` hold a valid instruction.
- `instr_ready  in  1`: consumer accepts this cycle.
- `redirect_valid  in  1`: load new PC, flush.
- `redirect_pc  in  16`: new PC.
- `halted  out  1`: fetch stopped on HALT (see Configuration).

## Operation
- First-word layout: [15:12] opcode, [11] imm_valid, [10:8] funct, [7:4] dest_reg, [3:0] src_reg. If imm_valid=1, the next word is `imm`; otherwise `imm`=16'h0000.
- `pc`: 16-bit word address, increments by 1 per word fetched, wraps 16'hFFFF→16'h0000. A long instruction at FFFF takes its imm from 0000.
- FSM states: IDLE, REQ, OPW, IMMW, OUT, HALT.
  - IDLE: reset state; no request; next state REQ.
  - REQ: `mem_req`=1, `mem_addr`=pc; next state OPW.
  - OPW: capture word fields into `instr`, `instr_pc`←pc, pc←pc+1. If word[11]=1, `mem_req`=1, `mem_addr`=pc+1 in the same cycle, next state IMMW. Otherwise `imm`←0, next state OUT.
  - IMMW: `imm`←mem_rdata, pc←pc+1; next state OUT.
  - OUT: `instr_valid`=1. `instr` and `instr_pc` stay stable while `instr_ready`=0. When `instr_ready`=1, next state REQ.
- `mem_req`/`mem_addr` are combinational from state; `mem_addr`=0 when `mem_req`=0.
- Redirect has priority in every state. It forces pc←redirect_pc and next state REQ, discards any in-flight read data, and drops `instr_valid` next cycle. A handshake in OUT in the same cycle still counts as consumed. Redirect in IDLE also applies.
- Reset, including mid-instruction: state IDLE, pc=RESET_PC. `instr`=0, `instr_pc`=0, `instr_valid`=0, `mem_req`=0, `mem_addr`=0, `halted`=0.

## Timing
- Short instruction, REQ at cycle 0: OPW at 1, `instr_valid`=1 at 2.
- Long instruction, REQ at cycle 0: imm request at 1, IMMW at 2, `instr_valid`=1 at 3.
- Back-to-back with `instr_ready` held high: 3 cycles per short instruction, 4 per long. The handshake cycle is followed by REQ.
- After reset deassert: IDLE 1 cycle, REQ the next.
- After redirect at cycle n: REQ at n+1 with `mem_addr`=redirect_pc.

## Configuration
- `MALUCH_FETCH_HALT_EN` defined: HALT is opcode 4'hF with funct 3'b111.
  - It is delivered normally.
  - On its handshake the FSM goes to HALT: no requests, `halted`=1.
  - It leaves HALT only on redirect (to REQ, `halted`=0) or reset.
- Not defined: no HALT state, `halted` tied 0, opcode F/funct 7 fetched like any other instruction.

## Structure
- Add `fetch_state_t` (enum of the six states) to package `types`, plus localparams for the first-word field positions. `instr_t` is reused unchanged.
- Single module with no sub-module. FSM, pc register and output register all sit in `instr_fetch`.

## Test plan
- Reset with RESET_PC=16'h0010, memory[10]=16'h1234, ready=1: first `mem_addr`=0010 in cycle 2 after reset. Cycle 4: `instr` fields opcode 1, imm_valid 0, funct 2, dest 3, src 4, imm 0000, `instr_pc`=0010.
- memory[0]=16'h2812, memory[1]=16'hBEEF: `instr` has imm_valid 1, imm BEEF. Next request addr 0002.
- `instr_ready`=0 for 5 cycles in OUT: `instr` stable, no `mem_req`. Releasing ready gives REQ the next cycle.
- `redirect_valid`=1 with `redirect_pc`=16'h0040 during IMMW: the old instruction is never presented and the next `mem_addr`=0040.
- Long instruction at FFFF: imm read from 0000, next fetch at 0001.
- With `MALUCH_FETCH_HALT_EN`, word F7xx: delivered, then `halted`=1 and no `mem_req` for 10 cycles. Redirect to 0 resumes fetching.
